// File: rtl/ctr_seq_checker_pkg.sv
// Shared state encoding for the counter-sequence checker.
package ctr_seq_checker_pkg;

    // IDLE   | waiting for the first sample, which only seeds the prediction
    // ACQ    | counting consecutive correct samples toward lock
    // LOCKED | stream follows prev+1; any break raises err_o
    // 2'd3 is unreachable and falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } seq_state_e;

endpackage

// File: rtl/sat_ctr.sv
// Saturating up-counter: counts inc_i pulses and sticks at all-ones.
module sat_ctr #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ctr_seq_checker.sv
// Monitor for free-running up-counter streams: locks after LockCount good samples, flags breaks.
// Optional saturating error total on err_cnt_o when SEQ_CHK_ERR_CNT_EN is defined.
module ctr_seq_checker
    import ctr_seq_checker_pkg::*;
#(
    parameter int unsigned Width     = 4,
    parameter int unsigned LockCount = 3,
    parameter int unsigned ErrWidth  = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    input  logic [Width-1:0]    d_i,
    output logic                locked_o,
    output logic                err_o,
    output logic [Width-1:0]    expected_o
`ifdef SEQ_CHK_ERR_CNT_EN
   ,output logic [ErrWidth-1:0] err_cnt_o
`endif
);

    localparam int unsigned GoodW = $clog2(LockCount + 1);

    if ((Width < 1) || (LockCount < 1) || (ErrWidth < 1)) begin : g_param_chk
        $error("ctr_seq_checker: Width, LockCount and ErrWidth must all be >= 1");
    end

    seq_state_e       state_q, state_d;
    logic [GoodW-1:0] good_q, good_d;
    logic [Width-1:0] expected_q, expected_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             match;

    assign match = (d_i == expected_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            good_q     <= '0;
            expected_q <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            expected_q <= expected_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_i) state_d = ACQ;
            end
            ACQ: begin
                if (valid_i && match && (good_q == GoodW'(LockCount - 1))) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (valid_i && !match) state_d = ACQ;
            end
            default: state_d = IDLE;
        endcase
    end

    // The prediction follows every sample, so a break re-seeds from the offending value.
    always_comb begin
        good_d     = good_q;
        expected_d = expected_q;
        err_d      = 1'b0;
        if (valid_i) begin
            expected_d = d_i + Width'(1);
        end
        case (state_q)
            IDLE: begin
                if (valid_i) good_d = '0;
            end
            ACQ: begin
                if (valid_i) good_d = match ? (good_q + GoodW'(1)) : '0;
            end
            LOCKED: begin
                if (valid_i && !match) begin
                    good_d = '0;
                    err_d  = 1'b1;
                end
            end
            default: good_d = '0;
        endcase
        locked_d = (state_d == LOCKED);
    end

    assign locked_o   = locked_q;
    assign err_o      = err_q;
    assign expected_o = expected_q;

`ifdef SEQ_CHK_ERR_CNT_EN
    // Counted on err_d so the total moves on the same edge that raises err_o.
    sat_ctr #(
        .Width (ErrWidth)
    ) u_err_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (err_d),
        .cnt_o  (err_cnt_o)
    );
`endif

endmodule

// File: tb/tb_ctr_seq_checker.sv
// Self-checking bench for ctr_seq_checker (Width=4, LockCount=3, ErrWidth=2).
module tb_ctr_seq_checker;

    localparam int W       = 4;
    localparam int LOCK    = 3;
    localparam int EW      = 2;
    localparam int MOD     = 1 << W;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [W-1:0]  d = '0;
    logic          locked;
    logic          err;
    logic [W-1:0]  expected;
`ifdef SEQ_CHK_ERR_CNT_EN
    logic [EW-1:0] err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: stream-level view of the rules.
    bit m_seeded;
    int m_exp;
    int m_run;
    bit m_locked;
    bit m_err;
    int m_errcnt;

    always #5 clk = ~clk;

    ctr_seq_checker #(
        .Width     (W),
        .LockCount (LOCK),
        .ErrWidth  (EW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid),
        .d_i        (d),
        .locked_o   (locked),
        .err_o      (err),
        .expected_o (expected)
`ifdef SEQ_CHK_ERR_CNT_EN
       ,.err_cnt_o  (err_cnt)
`endif
    );

    task automatic model_reset();
        m_seeded = 0; m_exp = 0; m_run = 0; m_locked = 0; m_err = 0; m_errcnt = 0;
    endtask

    task automatic model_step(input bit v, input int dv);
        m_err = 0;
        if (v) begin
            if (!m_seeded) begin
                m_seeded = 1;
                m_run = 0;
            end else if (dv == m_exp) begin
                if (!m_locked) begin
                    m_run++;
                    if (m_run >= LOCK) m_locked = 1;
                end
            end else begin
                if (m_locked) begin
                    m_err = 1;
                    if (m_errcnt < ERR_MAX) m_errcnt++;
                end
                m_locked = 0;
                m_run = 0;
            end
            m_exp = (dv + 1) % MOD;
        end
    endtask

    // Drive one cycle from posedge+1, sample at the next posedge+1.
    task automatic cycle(input bit v, input int dv);
        valid = v;
        d = W'(dv);
        @(posedge clk);
        #1;
        model_step(v, dv);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got %0b want 0", locked); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0b want 0", err); end
        n_cmp++; if (expected !== '0) begin n_bad++; $display("FAIL reset_expected got %0d want 0", expected); end
`ifdef SEQ_CHK_ERR_CNT_EN
        n_cmp++; if (err_cnt !== '0) begin n_bad++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, i);
            n_cmp++; if (locked !== m_locked) begin n_bad++; $display("FAIL lock_locked s=%0d got %0b want %0b", i, locked, m_locked); end
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL lock_err s=%0d got %0b want 0", i, err); end
            n_cmp++; if (expected !== W'(m_exp)) begin n_bad++; $display("FAIL lock_expected s=%0d got %0d want %0d", i, expected, m_exp); end
        end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_after_s3 got %0b want 1", locked); end
    endtask

    task automatic test_wrap();
        for (int i = 4; i <= 17; i++) begin
            cycle(1'b1, i % MOD);
            n_cmp++; if (locked !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL wrap d=%0d locked=%0b err=%0b want 1/0", i % MOD, locked, err); end
            n_cmp++; if (expected !== W'((i + 1) % MOD)) begin n_bad++; $display("FAIL wrap_expected got %0d want %0d", expected, (i + 1) % MOD); end
        end
    endtask

    task automatic test_break();
        for (int i = 2; i <= 4; i++) cycle(1'b1, i);
        cycle(1'b1, 7);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL break_err got %0b want 1", err); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL break_locked got %0b want 0", locked); end
        n_cmp++; if (expected !== 4'd8) begin n_bad++; $display("FAIL break_expected got %0d want 8", expected); end
        for (int i = 8; i <= 10; i++) begin
            cycle(1'b1, i);
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL break_err_pulse d=%0d got %0b want 0", i, err); end
            n_cmp++; if (locked !== m_locked) begin n_bad++; $display("FAIL relock d=%0d got %0b want %0b", i, locked, m_locked); end
        end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL relock_final got %0b want 1", locked); end
    endtask

    task automatic test_valid_hold();
        logic [W-1:0] exp_hold;
        exp_hold = W'(m_exp);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, int'($urandom_range(0, MOD - 1)));
            n_cmp++; if (locked !== 1'b1 || err !== 1'b0 || expected !== exp_hold) begin
                n_bad++; $display("FAIL hold c=%0d locked=%0b err=%0b exp=%0d want 1/0/%0d", i, locked, err, expected, exp_hold);
            end
        end
        cycle(1'b1, int'(exp_hold));
        n_cmp++; if (err !== 1'b0 || locked !== 1'b1) begin n_bad++; $display("FAIL hold_resume err=%0b locked=%0b want 0/1", err, locked); end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, m_exp);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL async_locked got %0b want 0", locked); end
        n_cmp++; if (expected !== '0) begin n_bad++; $display("FAIL async_expected got %0d want 0", expected); end
`ifdef SEQ_CHK_ERR_CNT_EN
        n_cmp++; if (err_cnt !== '0) begin n_bad++; $display("FAIL async_err_cnt got %0d want 0", err_cnt); end
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 5; i <= 8; i++) begin
            cycle(1'b1, i);
            n_cmp++; if (locked !== ((i == 8) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL async_relock d=%0d got %0b want %0b", i, locked, i == 8); end
        end
    endtask

    task automatic test_err_cnt();
        int want [5] = '{1, 2, 3, 3, 3};
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, (m_exp + 3) % MOD);
            n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL errcnt_pulse k=%0d got %0b want 1", k, err); end
`ifdef SEQ_CHK_ERR_CNT_EN
            n_cmp++; if (err_cnt !== EW'(want[k])) begin n_bad++; $display("FAIL errcnt k=%0d got %0d want %0d", k, err_cnt, want[k]); end
`else
            if (want[k] < 0) $display("unexpected table entry");
`endif
            for (int j = 0; j < LOCK; j++) cycle(1'b1, m_exp);
            n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL errcnt_relock k=%0d got %0b want 1", k, locked); end
        end
    endtask

    task automatic test_random();
        bit v;
        int dv;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            dv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MOD - 1)) : m_exp;
            cycle(v, dv);
            n_cmp++; if (locked !== m_locked || err !== m_err || expected !== W'(m_exp)) begin
                n_bad++; $display("FAIL random c=%0d locked=%0b err=%0b exp=%0d want %0b/%0b/%0d", i, locked, err, expected, m_locked, m_err, m_exp);
            end
`ifdef SEQ_CHK_ERR_CNT_EN
            n_cmp++; if (err_cnt !== EW'(m_errcnt)) begin n_bad++; $display("FAIL random_err_cnt c=%0d got %0d want %0d", i, err_cnt, m_errcnt); end
`endif
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_lock();
        test_wrap();
        test_break();
        test_valid_hold();
        test_async_reset();
        test_err_cnt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
